// File: rtl/poly_vec_add_mod.sv
// rtl/poly_vec_add_mod.sv - chunked u = x + e_1, v = y + e_2 + msg_poly adder with optional mod-Q reduction
module poly_vec_add_mod #(
  parameter  int K      = 3,
  parameter  int N      = 256,
  parameter  int COEF_W = 12,
  parameter  int Q      = 3329,
  parameter  int LANES  = 16,
  parameter  int REDUCE = 1,
  localparam int U_W    = (REDUCE != 0) ? COEF_W : COEF_W + 1,
  localparam int V_W    = (REDUCE != 0) ? COEF_W : COEF_W + 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [K*N*COEF_W-1:0] x,
  input  logic [K*N*COEF_W-1:0] e_1,
  input  logic [N*COEF_W-1:0]   y,
  input  logic [N*COEF_W-1:0]   e_2,
  input  logic [N*COEF_W-1:0]   msg_poly,
  output logic [K*N*U_W-1:0]    u,
  output logic [N*V_W-1:0]      v,
  output logic                  busy,
  output logic                  done,
  output logic                  valid
);

  localparam int C  = N / LANES;
  localparam int CW = (C > 1) ? $clog2(C) : 1;
  localparam int PW = $clog2(K);
  localparam logic [CW-1:0]     C_LAST = CW'(C - 1);
  localparam logic [PW-1:0]     P_LAST = PW'(K - 1);
  localparam logic [COEF_W:0]   Q_U    = (COEF_W + 1)'(Q);
  localparam logic [COEF_W+1:0] Q_V    = (COEF_W + 2)'(Q);
  localparam logic [COEF_W+1:0] Q2_V   = (COEF_W + 2)'(2 * Q);

  typedef enum logic [1:0] {IDLE, U_PASS, V_PASS, FINISH} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        p_q, p_d;
  logic [CW-1:0]        c_q, c_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 valid_q, valid_d;
  logic [K*N*U_W-1:0]   u_q, u_d;
  logic [N*V_W-1:0]     v_q, v_d;

  function automatic logic [U_W-1:0] red_u(input logic [COEF_W:0] s);
    logic [COEF_W:0] r;
    r = s;
    if (REDUCE != 0 && s >= Q_U) r = s - Q_U;
    return r[U_W-1:0];
  endfunction

  // Inputs are < Q when reducing, so the three-term sum is < 3Q.
  function automatic logic [V_W-1:0] red_v(input logic [COEF_W+1:0] s);
    logic [COEF_W+1:0] r;
    r = s;
    if (REDUCE != 0) begin
      if (s >= Q2_V)     r = s - Q2_V;
      else if (s >= Q_V) r = s - Q_V;
    end
    return r[V_W-1:0];
  endfunction

  int                base;
  logic [COEF_W:0]   s_u;
  logic [COEF_W+1:0] s_v;

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    c_d     = c_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    u_d     = u_q;
    v_d     = v_q;
    base    = 0;
    s_u     = '0;
    s_v     = '0;
    case (state_q)
      IDLE: begin
        // done_q marks the completion cycle, in which start is deliberately ignored.
        if (start && !done_q) begin
          state_d = U_PASS;
          p_d     = '0;
          c_d     = '0;
          busy_d  = 1'b1;
          valid_d = 1'b0;
        end
      end
      U_PASS: begin
        for (int l = 0; l < LANES; l++) begin
          base = int'(p_q) * N + int'(c_q) * LANES + l;
          s_u  = {1'b0, x[base*COEF_W +: COEF_W]} + {1'b0, e_1[base*COEF_W +: COEF_W]};
          u_d[base*U_W +: U_W] = red_u(s_u);
        end
        if (c_q == C_LAST) begin
          c_d = '0;
          if (p_q == P_LAST) state_d = V_PASS;
          else               p_d = p_q + 1'b1;
        end else begin
          c_d = c_q + 1'b1;
        end
      end
      V_PASS: begin
        for (int l = 0; l < LANES; l++) begin
          base = int'(c_q) * LANES + l;
          s_v  = {2'b0, y[base*COEF_W +: COEF_W]} + {2'b0, e_2[base*COEF_W +: COEF_W]}
               + {2'b0, msg_poly[base*COEF_W +: COEF_W]};
          v_d[base*V_W +: V_W] = red_v(s_v);
        end
        if (c_q == C_LAST) begin
          c_d     = '0;
          state_d = FINISH;
        end else begin
          c_d = c_q + 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
        p_d     = '0;
        done_d  = 1'b1;
        valid_d = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      c_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      u_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      u_q     <= u_d;
      v_q     <= v_d;
    end
  end

  assign u     = u_q;
  assign v     = v_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_poly_vec_add_mod.sv
// tb/tb_poly_vec_add_mod.sv - directed checks of poly_vec_add_mod across reduce modes and lane configs
module tb_poly_vec_add_mod;

  localparam int N  = 256;
  localparam int W  = 12;
  localparam int Q  = 3329;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] st = 4'b0;
  logic [4*N*W-1:0] x4, e4;
  logic [N*W-1:0]   y, e2, m;

  logic [3*N*W-1:0]  u_a;  logic [N*W-1:0]  v_a;
  logic [3*N*13-1:0] u_b;  logic [N*14-1:0] v_b;
  logic [2*N*W-1:0]  u_c;  logic [N*W-1:0]  v_c;
  logic [4*N*W-1:0]  u_d;  logic [N*W-1:0]  v_d;
  logic [3:0] bz, dn, vl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  poly_vec_add_mod #(.K(3), .LANES(16), .REDUCE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .x(x4[3*N*W-1:0]), .e_1(e4[3*N*W-1:0]),
    .y(y), .e_2(e2), .msg_poly(m), .u(u_a), .v(v_a), .busy(bz[0]), .done(dn[0]), .valid(vl[0]));
  poly_vec_add_mod #(.K(3), .LANES(16), .REDUCE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .x(x4[3*N*W-1:0]), .e_1(e4[3*N*W-1:0]),
    .y(y), .e_2(e2), .msg_poly(m), .u(u_b), .v(v_b), .busy(bz[1]), .done(dn[1]), .valid(vl[1]));
  poly_vec_add_mod #(.K(2), .LANES(256), .REDUCE(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .x(x4[2*N*W-1:0]), .e_1(e4[2*N*W-1:0]),
    .y(y), .e_2(e2), .msg_poly(m), .u(u_c), .v(v_c), .busy(bz[2]), .done(dn[2]), .valid(vl[2]));
  poly_vec_add_mod #(.K(4), .LANES(1), .REDUCE(1)) dut_d (
    .clk(clk), .rst_n(rst_n), .start(st[3]), .x(x4), .e_1(e4),
    .y(y), .e_2(e2), .msg_poly(m), .u(u_d), .v(v_d), .busy(bz[3]), .done(dn[3]), .valid(vl[3]));

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill(input int mode);
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < N; i++) begin
        x4[(j*N+i)*W +: W] = (mode == 0) ? 12'd3328 : W'((j*256 + i) % Q);
        e4[(j*N+i)*W +: W] = (mode == 0) ? 12'd1 : 12'd0;
      end
    for (int i = 0; i < N; i++) begin
      y[i*W +: W]  = (mode == 0) ? 12'd3328 : W'(i);
      e2[i*W +: W] = (mode == 0) ? 12'd3328 : 12'd0;
      m[i*W +: W]  = (mode == 0) ? 12'd1665 : 12'd0;
    end
  endtask

  task automatic run(input int id, input int exp_lat, input string tag);
    int lat;
    @(negedge clk) st[id] = 1'b1;
    @(posedge clk);
    @(negedge clk) st[id] = 1'b0;
    lat = 0;
    while (lat < 3000) begin
      @(posedge clk);
      lat++;
      #1;
      if (dn[id]) break;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_valid"}, vl[id], 1);
  endtask

  // Compares every coefficient against the model; reports the first mismatch per polynomial.
  task automatic check_all(input int id, input string tag);
    int kk, got, exp, g1, e1v;
    bit bad;
    kk = (id == 2) ? 2 : (id == 3) ? 4 : 3;
    for (int j = 0; j <= kk; j++) begin
      bad = 0; g1 = 0; e1v = 0;
      for (int i = 0; i < N; i++) begin
        if (j < kk) begin
          exp = int'(x4[(j*N+i)*W +: W]) + int'(e4[(j*N+i)*W +: W]);
          case (id)
            0: got = int'(u_a[(j*N+i)*W +: W]);
            1: got = int'(u_b[(j*N+i)*13 +: 13]);
            2: got = int'(u_c[(j*N+i)*W +: W]);
            default: got = int'(u_d[(j*N+i)*W +: W]);
          endcase
        end else begin
          exp = int'(y[i*W +: W]) + int'(e2[i*W +: W]) + int'(m[i*W +: W]);
          case (id)
            0: got = int'(v_a[i*W +: W]);
            1: got = int'(v_b[i*14 +: 14]);
            2: got = int'(v_c[i*W +: W]);
            default: got = int'(v_d[i*W +: W]);
          endcase
        end
        if (id != 1) exp = exp % Q;
        if (!bad) begin g1 = got; e1v = exp; end
        if (got != exp) bad = 1;
      end
      chk($sformatf("%s_%s%0d", tag, (j < kk) ? "u" : "v", j), g1, e1v);
    end
  endtask

  initial begin
    int ndone, first_done;
    logic v66, v67, b67;
    fill(0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_u_zero", (u_a == '0) ? 1 : 0, 1);
    chk("rst_busy", bz[0], 0);
    chk("rst_valid", vl[0], 0);
    chk("rst_done", dn[0], 0);
    @(negedge clk) rst_n = 1'b1;

    run(0, 65, "const_a");
    chk("const_a_u0", u_a[11:0], 0);
    chk("const_a_v0", v_a[11:0], 1663);
    check_all(0, "const_a");
    run(1, 65, "const_b");
    chk("const_b_u0", u_b[12:0], 3329);
    chk("const_b_v0", v_b[13:0], 8321);
    check_all(1, "const_b");

    fill(1);
    @(negedge clk) st[0] = 1'b1;
    @(posedge clk);
    @(negedge clk) st[0] = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_u_zero", (u_a == '0) ? 1 : 0, 1);
    chk("midrst_v_zero", (v_a == '0) ? 1 : 0, 1);
    chk("midrst_busy", bz[0], 0);
    chk("midrst_valid", vl[0], 0);
    @(negedge clk) rst_n = 1'b1;

    run(0, 65, "lane_a");
    check_all(0, "lane_a");
    run(1, 65, "lane_b");
    check_all(1, "lane_b");
    run(2, 4, "lane_c");
    check_all(2, "lane_c");
    run(3, 1281, "lane_d");
    check_all(3, "lane_d");

    ndone = 0; first_done = 0; v66 = 1'b0; v67 = 1'b1; b67 = 1'b0;
    @(negedge clk) st[0] = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 70; cyc++) begin
      @(posedge clk);
      #1;
      if (dn[0]) begin ndone++; first_done = cyc; end
      if (cyc == 66) v66 = vl[0];
      if (cyc == 67) begin v67 = vl[0]; b67 = bz[0]; end
    end
    st[0] = 1'b0;
    chk("hs_done_count", ndone, 1);
    chk("hs_done_cycle", first_done, 65);
    chk("hs_valid_done_cycle", v66, 1);
    chk("hs_valid_dropped", v67, 0);
    chk("hs_busy_restart", b67, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
